// File: rtl/rsa_arbiter.sv
// Two-requester round-robin front end for a single RSA modexp engine.
// Optional engine watchdog is compiled in with `define RSA_ARB_TIMEOUT_EN.
module rsa_arbiter #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic         req1,
   input  logic [255:0] data0,
   input  logic [255:0] data1,
   input  logic [31:0]  pow0,
   input  logic [31:0]  pow1,
   output logic         ack0,
   output logic         ack1,
   output logic         done0,
   output logic         done1,
   output logic [255:0] res_data,
   input  logic         cfg_we,
   input  logic [255:0] cfg_modulus,
   input  logic [31:0]  cfg_mp,
   output logic         cfg_busy,
   output logic         eng_start,
   output logic [255:0] eng_indata,
   output logic [31:0]  eng_pow,
   output logic [255:0] eng_modulus,
   output logic [31:0]  eng_mp,
   input  logic         eng_done,
   input  logic [255:0] eng_result,
   output logic         eng_abort,
   output logic         err
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

   state_t state;
   logic   last_gnt;
   logic   owner;
   logic   gnt;

   // On a tie the requester that did not win last time gets the grant.
   always_comb begin
      gnt = req1;
      if (req0 && req1)
         gnt = ~last_gnt;
   end

`ifdef RSA_ARB_TIMEOUT_EN
   logic [15:0] wdog;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign eng_abort      = 1'b0;
   assign err            = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last_gnt    <= 1'b1;
         owner       <= 1'b0;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         done0       <= 1'b0;
         done1       <= 1'b0;
         res_data    <= '0;
         cfg_busy    <= 1'b0;
         eng_start   <= 1'b0;
         eng_indata  <= '0;
         eng_pow     <= '0;
         eng_modulus <= '0;
         eng_mp      <= '0;
`ifdef RSA_ARB_TIMEOUT_EN
         eng_abort   <= 1'b0;
         err         <= 1'b0;
         wdog        <= '0;
`endif
      end else begin
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         done0     <= 1'b0;
         done1     <= 1'b0;
         eng_start <= 1'b0;
`ifdef RSA_ARB_TIMEOUT_EN
         eng_abort <= 1'b0;
         err       <= 1'b0;
`endif
         if (cfg_we && !cfg_busy) begin
            eng_modulus <= cfg_modulus;
            eng_mp      <= cfg_mp;
         end

         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  owner      <= gnt;
                  last_gnt   <= gnt;
                  eng_indata <= gnt ? data1 : data0;
                  eng_pow    <= gnt ? pow1 : pow0;
                  ack0       <= ~gnt;
                  ack1       <= gnt;
                  cfg_busy   <= 1'b1;
                  state      <= LOAD;
               end
            end
            LOAD: begin
               eng_start <= 1'b1;
`ifdef RSA_ARB_TIMEOUT_EN
               wdog      <= '0;
`endif
               state     <= RUN;
            end
            RUN: begin
               // A completion on the same cycle as the timeout takes priority.
               if (eng_done) begin
                  res_data <= eng_result;
                  done0    <= ~owner;
                  done1    <= owner;
                  state    <= FIN;
               end
`ifdef RSA_ARB_TIMEOUT_EN
               else if (wdog == TIMEOUT_CYCLES - 16'd1) begin
                  eng_abort <= 1'b1;
                  err       <= 1'b1;
                  cfg_busy  <= 1'b0;
                  state     <= IDLE;
               end else begin
                  wdog <= wdog + 16'd1;
               end
`endif
            end
            FIN: begin
               cfg_busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_arbiter.sv
// Directed self-checking bench for rsa_arbiter; exercises the watchdog
// path as well when built with `define RSA_ARB_TIMEOUT_EN.
module tb_rsa_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0, req1;
   logic [255:0] data0, data1;
   logic [31:0]  pow0, pow1;
   logic         ack0, ack1, done0, done1;
   logic [255:0] res_data;
   logic         cfg_we;
   logic [255:0] cfg_modulus;
   logic [31:0]  cfg_mp;
   logic         cfg_busy, eng_start;
   logic [255:0] eng_indata, eng_modulus;
   logic [31:0]  eng_pow, eng_mp;
   logic         eng_done;
   logic [255:0] eng_result;
   logic         eng_abort, err;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [255:0] mod_f;
   logic         seen_pulse;

   rsa_arbiter #(.TIMEOUT_CYCLES(16'd8)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .data0(data0), .data1(data1),
      .pow0(pow0), .pow1(pow1),
      .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
      .res_data(res_data),
      .cfg_we(cfg_we), .cfg_modulus(cfg_modulus), .cfg_mp(cfg_mp),
      .cfg_busy(cfg_busy), .eng_start(eng_start),
      .eng_indata(eng_indata), .eng_pow(eng_pow),
      .eng_modulus(eng_modulus), .eng_mp(eng_mp),
      .eng_done(eng_done), .eng_result(eng_result),
      .eng_abort(eng_abort), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // From the ack cycle (LOAD): start pulse, completion, done pulse, back to IDLE.
   task automatic finish_job(input string tag, input logic who, input logic [255:0] r);
      tick();
      check({tag, "_start"}, eng_start, 1'b1);
      eng_done   = 1'b1;
      eng_result = r;
      tick();
      eng_done = 1'b0;
      check({tag, "_done0"}, done0, !who);
      check({tag, "_done1"}, done1, who);
      check({tag, "_res"}, res_data, r);
      tick();
      check({tag, "_done_clr"}, done0 | done1, 1'b0);
      check({tag, "_idle"}, cfg_busy, 1'b0);
   endtask

   initial begin
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      data0 = '0; data1 = '0; pow0 = '0; pow1 = '0;
      cfg_we = 1'b0; cfg_modulus = '0; cfg_mp = '0;
      eng_done = 1'b0; eng_result = '0;
      mod_f = '1;
      mod_f[7:0] = 8'hFB;
      tick(); tick();
      check("rst_ack", {ack0, ack1, done0, done1}, 4'b0000);
      check("rst_busy", cfg_busy, 1'b0);
      check("rst_start", eng_start, 1'b0);
      check("rst_res", res_data, '0);
      check("rst_mod", eng_modulus, '0);
      check("rst_err", {eng_abort, err}, 2'b00);
      rst = 1'b0;
      tick();

      // configuration while idle
      cfg_we = 1'b1; cfg_modulus = mod_f; cfg_mp = 32'h0000_0005;
      tick();
      cfg_we = 1'b0;
      check("cfg_mod", eng_modulus, mod_f);
      check("cfg_mp", eng_mp, 32'h5);

      // single job from requester 0
      req0 = 1'b1; data0 = 256'h3; pow0 = 32'h11;
      tick();
      req0 = 1'b0;
      check("j1_ack0", ack0, 1'b1);
      check("j1_ack1", ack1, 1'b0);
      check("j1_busy", cfg_busy, 1'b1);
      check("j1_nostart", eng_start, 1'b0);
      tick();
      check("j1_start", eng_start, 1'b1);
      check("j1_ackclr", ack0, 1'b0);
      check("j1_indata", eng_indata, 256'h3);
      check("j1_pow", eng_pow, 32'h11);
      cfg_we = 1'b1; cfg_modulus = 256'h1234; cfg_mp = 32'h9;
      tick();
      cfg_we = 1'b0;
      check("j1_startclr", eng_start, 1'b0);
      check("cfg_busy_mod", eng_modulus, mod_f);
      check("cfg_busy_mp", eng_mp, 32'h5);
      eng_done = 1'b1; eng_result = 256'hABCD;
      tick();
      eng_done = 1'b0;
      check("j1_done0", done0, 1'b1);
      check("j1_done1", done1, 1'b0);
      check("j1_res", res_data, 256'hABCD);
      tick();
      check("j1_doneclr", done0, 1'b0);
      check("j1_idle", cfg_busy, 1'b0);
      check("cfg_dropped", eng_modulus, mod_f);

      // stray completion while idle is ignored
      eng_done = 1'b1; eng_result = 256'h5555;
      tick();
      eng_done = 1'b0;
      check("stray_res", res_data, 256'hABCD);
      check("stray_done", {done0, done1}, 2'b00);
      check("stray_busy", cfg_busy, 1'b0);

      // contention after reset: strict alternation 0,1,0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst2_res", res_data, '0);
      check("rst2_mod", eng_modulus, '0);
      req0 = 1'b1; req1 = 1'b1;
      data0 = 256'hA0; data1 = 256'hB1; pow0 = 32'h10; pow1 = 32'h20;
      tick();
      check("c1_ack", {ack0, ack1}, 2'b10);
      check("c1_indata", eng_indata, 256'hA0);
      finish_job("c1", 1'b0, 256'h111);
      check("c2_noack", {ack0, ack1}, 2'b00);
      tick();
      check("c2_ack", {ack0, ack1}, 2'b01);
      check("c2_indata", eng_indata, 256'hB1);
      check("c2_pow", eng_pow, 32'h20);
      finish_job("c2", 1'b1, 256'h222);
      tick();
      check("c3_ack", {ack0, ack1}, 2'b10);
      req0 = 1'b0; req1 = 1'b0;
      finish_job("c3", 1'b0, 256'h333);

      // request withdrawn before being served is never acked
      tick();
      check("drop_ack", {ack0, ack1, cfg_busy}, 3'b000);

      // reset in the middle of a running job
      req1 = 1'b1; data1 = 256'h77; pow1 = 32'h3;
      tick();
      req1 = 1'b0;
      check("r_ack1", ack1, 1'b1);
      tick();
      check("r_start", eng_start, 1'b1);
      for (int i = 0; i < 10; i++) tick();
      rst = 1'b1;
      #1;
      check("r_busy", cfg_busy, 1'b0);
      check("r_res", res_data, '0);
      check("r_indata", eng_indata, '0);
      check("r_pow", eng_pow, '0);
      check("r_done", {done0, done1, eng_start}, 3'b000);
      tick();
      rst = 1'b0;
      seen_pulse = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         seen_pulse = seen_pulse | done0 | done1;
      end
      check("r_nodone", seen_pulse, 1'b0);
      req0 = 1'b1; data0 = 256'h9; pow0 = 32'h4;
      tick();
      req0 = 1'b0;
      check("r_next_ack0", ack0, 1'b1);
      check("r_next_indata", eng_indata, 256'h9);
      tick();
      check("r_next_start", eng_start, 1'b1);

`ifdef RSA_ARB_TIMEOUT_EN
      // watchdog expires on the 8th RUN cycle
      for (int i = 0; i < 7; i++) tick();
      check("t_pre", {eng_abort, err, cfg_busy}, 3'b001);
      tick();
      check("t_abort", {eng_abort, err}, 2'b11);
      check("t_idle", cfg_busy, 1'b0);
      check("t_nodone", {done0, done1}, 2'b00);
      tick();
      check("t_clr", {eng_abort, err}, 2'b00);
      // completion on the 8th cycle beats the watchdog
      req1 = 1'b1;
      tick();
      req1 = 1'b0;
      check("t2_ack1", ack1, 1'b1);
      tick();
      for (int i = 0; i < 7; i++) tick();
      eng_done = 1'b1; eng_result = 256'hBEEF;
      tick();
      eng_done = 1'b0;
      check("t2_done1", done1, 1'b1);
      check("t2_noerr", {eng_abort, err}, 2'b00);
      check("t2_res", res_data, 256'hBEEF);
      tick();
      check("t2_idle", cfg_busy, 1'b0);
`else
      // no watchdog: the job waits well past any timeout
      seen_pulse = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         seen_pulse = seen_pulse | err | eng_abort | done0 | done1;
      end
      check("nt_quiet", seen_pulse, 1'b0);
      check("nt_busy", cfg_busy, 1'b1);
      eng_done = 1'b1; eng_result = 256'hBEEF;
      tick();
      eng_done = 1'b0;
      check("nt_done0", done0, 1'b1);
      check("nt_res", res_data, 256'hBEEF);
      tick();
      check("nt_idle", cfg_busy, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
